cpu_6502_uop_sequencer: RTL
===========================

CPU_6502_UOP_SEQUENCER -- requirements
Module: cpu_6502_uop_sequencer

Interface
REQ-001 SHALL use one clock and a synchronous active-low reset: i_clk  in  1  rising-edge clock; i_rstn  in  1  synchronous reset, active low.
REQ-002 SHALL have i_rdy  in  1  CPU RDY; low freezes the sequencer.
REQ-003 SHALL have i_opcode  in  8  data-bus byte sampled at fetch.
REQ-004 SHALL have i_uop_entry  in  11  first-uop address decoded from i_opcode by the entry block.
REQ-005 SHALL have i_uop_ctrl  in  3  next-address control field of the current micro-word.
REQ-006 SHALL have i_uop_target  in  11  jump/branch target field of the current micro-word.
REQ-007 SHALL have i_cond  in  1  condition selected by the current micro-word.
REQ-008 SHALL have i_nmi_n  in  1  NMI, edge-triggered on falling edge.
REQ-009 SHALL have i_irq_n  in  1  IRQ, level-triggered, active low.
REQ-010 SHALL have i_iflag  in  1  P.I; 1 masks IRQ.
REQ-011 SHALL have o_uop_addr  out  11  registered micro-ROM address.
REQ-012 SHALL have o_ir  out  8  registered instruction register.
REQ-013 SHALL have o_int_kind  out  2  registered: 0 BRK/none, 1 IRQ, 2 NMI, 3 RESET.
REQ-014 SHALL have o_sync  out  1  combinational; 1 when i_uop_ctrl==FETCH.

Function
REQ-015 SHALL define control codes: 000 NEXT, 001 FETCH, 010 JUMP, 011 BRANCH, 100 HOLD; 101-111 SHALL behave as NEXT.
REQ-016 NEXT: o_uop_addr <= o_uop_addr+1, 11-bit wrap (11'h7FF -> 11'h000).
REQ-017 JUMP: o_uop_addr <= i_uop_target.
REQ-018 BRANCH: i_cond=1 -> i_uop_target; i_cond=0 -> +1.
REQ-019 HOLD: i_cond=0 -> address unchanged; i_cond=1 -> +1.
REQ-020 FETCH, priority NMI > IRQ > opcode: nmi_pending=1 -> o_uop_addr<=11'h108, o_ir<=8'h00, o_int_kind<=2; else i_irq_n=0 and i_iflag=0 -> 11'h110, o_ir<=8'h00, o_int_kind<=1; else o_uop_addr<=i_uop_entry, o_ir<=i_opcode, o_int_kind<=0.
REQ-021 Latency: each update SHALL occur at the first rising edge after the cycle presenting i_uop_ctrl, i.e. one cycle.
REQ-022 o_ir and o_int_kind SHALL change only on FETCH or reset.
REQ-023 NMI detector: 1-bit register of previous i_nmi_n; pending set when previous=1 and current=0; detector runs regardless of i_rdy.
REQ-024 FETCH decision SHALL use the registered pending bit only; an edge arriving in the FETCH cycle is serviced at the next FETCH.
REQ-025 Pending SHALL clear when NMI entry is taken; a new edge in that same cycle SHALL leave pending=1.
REQ-026 i_rdy=0: o_uop_addr, o_ir, o_int_kind SHALL hold; i_uop_ctrl is ignored.

Reset
REQ-027 i_rstn=0 at a rising edge: o_uop_addr<=11'h100, o_ir<=8'h00, o_int_kind<=3, nmi_pending<=0, previous-NMI register<=1; overrides i_rdy and any in-flight uop.
REQ-028 Reset mid-instruction SHALL discard the instruction; no partial state retained.

Configuration
REQ-029 Macro CPU_6502_UOP_INSTR_CNT_EN: defined -> adds port o_instr_cnt  out  32, reset to 0, incremented on every FETCH edge with i_rdy=1 (including interrupt entries), wraps 32'hFFFFFFFF -> 0; undefined -> port and counter absent, all other behaviour identical.

Verification
REQ-030 Reset, then ctrl=NEXT x3 with i_rdy=1 -> o_uop_addr 100,101,102,103; o_int_kind=3.
REQ-031 ctrl=FETCH, i_opcode=8'hA9, i_uop_entry=11'h0A9, no interrupts -> next cycle o_uop_addr=0A9, o_ir=A9, o_int_kind=0.
REQ-032 Falling i_nmi_n two cycles before FETCH with i_irq_n=0, i_iflag=0 -> o_uop_addr=108, o_ir=00, o_int_kind=2; next FETCH with IRQ still low -> 110, o_int_kind=1.
REQ-033 o_uop_addr=7FF, ctrl=NEXT -> 000; ctrl=BRANCH, target 055, i_cond=0 -> 001, i_cond=1 -> 055; ctrl=HOLD, i_cond=0 for 3 cycles -> address unchanged.
REQ-034 i_rdy=0 for 4 cycles during ctrl=JUMP, with NMI edge inside the stall -> address frozen; jump taken on the first i_rdy=1 edge; NMI entry taken at the following FETCH.
REQ-035 i_rstn=0 one cycle mid-instruction at address 0A9 -> 100, o_int_kind=3; with macro: o_instr_cnt counts 5 after 5 FETCHes and returns to 0 on reset.

Source files
------------

// File: rtl/cpu_6502_uop_sequencer_if.sv
// cpu_6502_uop_sequencer_if: bundles the micro-sequencer's control inputs and
// registered outputs. Clock and reset stay outside as plain module ports.
//   i_rdy        CPU RDY, low freezes the sequencer
//   i_opcode     data-bus byte sampled at fetch
//   i_uop_entry  first micro-op address decoded from i_opcode
//   i_uop_ctrl   next-address control field of the current micro-word
//   i_uop_target jump/branch target of the current micro-word
//   i_cond       condition selected by the current micro-word
//   i_nmi_n      NMI, falling-edge triggered
//   i_irq_n      IRQ, level, active low
//   i_iflag      P.I, 1 masks IRQ
//   o_uop_addr   registered micro-ROM address
//   o_ir         registered instruction register
//   o_int_kind   registered entry kind: 0 BRK/none, 1 IRQ, 2 NMI, 3 RESET
//   o_sync       combinational, 1 while the current micro-word is FETCH
// master: drives the inputs (CPU / testbench); slave: the sequencer.
interface cpu_6502_uop_sequencer_if;
  localparam int unsigned ADDR_W = 11;
  localparam int unsigned OP_W   = 8;
  localparam int unsigned CTRL_W = 3;
  localparam int unsigned KIND_W = 2;

  logic              i_rdy;
  logic [OP_W-1:0]   i_opcode;
  logic [ADDR_W-1:0] i_uop_entry;
  logic [CTRL_W-1:0] i_uop_ctrl;
  logic [ADDR_W-1:0] i_uop_target;
  logic              i_cond;
  logic              i_nmi_n;
  logic              i_irq_n;
  logic              i_iflag;
  logic [ADDR_W-1:0] o_uop_addr;
  logic [OP_W-1:0]   o_ir;
  logic [KIND_W-1:0] o_int_kind;
  logic              o_sync;

  modport master (
    output i_rdy, i_opcode, i_uop_entry, i_uop_ctrl, i_uop_target,
           i_cond, i_nmi_n, i_irq_n, i_iflag,
    input  o_uop_addr, o_ir, o_int_kind, o_sync
  );

  modport slave (
    input  i_rdy, i_opcode, i_uop_entry, i_uop_ctrl, i_uop_target,
           i_cond, i_nmi_n, i_irq_n, i_iflag,
    output o_uop_addr, o_ir, o_int_kind, o_sync
  );
endinterface

// File: rtl/cpu_6502_uop_sequencer.sv
// cpu_6502_uop_sequencer: next-address logic for a 6502 micro-coded core.
// Each cycle with i_rdy=1 the micro-word's control field selects the next
// micro-ROM address (NEXT/FETCH/JUMP/BRANCH/HOLD). FETCH loads the
// instruction register or enters an interrupt sequence (NMI > IRQ > opcode).
// Ports:
//   i_clk        rising-edge clock
//   i_rstn       synchronous reset, active low
//   bus          cpu_6502_uop_sequencer_if.slave (see interface header)
//   o_instr_cnt  32-bit FETCH counter, only with CPU_6502_UOP_INSTR_CNT_EN
// Optional feature macro: CPU_6502_UOP_INSTR_CNT_EN.
module cpu_6502_uop_sequencer (
  input  logic i_clk,
  input  logic i_rstn,
  cpu_6502_uop_sequencer_if.slave bus
`ifdef CPU_6502_UOP_INSTR_CNT_EN
  ,
  output logic [31:0] o_instr_cnt
`endif
);
  localparam int unsigned ADDR_W = 11;
  localparam int unsigned OP_W   = 8;
  localparam int unsigned KIND_W = 2;
  localparam int unsigned CNT_W  = 32;

  localparam logic [ADDR_W-1:0] ADDR_RESET = 11'h100;
  localparam logic [ADDR_W-1:0] ADDR_NMI   = 11'h108;
  localparam logic [ADDR_W-1:0] ADDR_IRQ   = 11'h110;

  localparam logic [KIND_W-1:0] KIND_NONE  = 2'd0;
  localparam logic [KIND_W-1:0] KIND_IRQ   = 2'd1;
  localparam logic [KIND_W-1:0] KIND_NMI   = 2'd2;
  localparam logic [KIND_W-1:0] KIND_RESET = 2'd3;

  typedef enum logic [2:0] {
    UOP_NEXT   = 3'b000,
    UOP_FETCH  = 3'b001,
    UOP_JUMP   = 3'b010,
    UOP_BRANCH = 3'b011,
    UOP_HOLD   = 3'b100
  } uop_ctrl_e;

  logic [ADDR_W-1:0] addr_q, addr_d, addr_inc;
  logic [OP_W-1:0]   ir_q, ir_d;
  logic [KIND_W-1:0] kind_q, kind_d;
  logic              nmi_prev_q, nmi_pending_q, nmi_pending_d;
  logic              nmi_edge, take_nmi, fetch_fire;
  uop_ctrl_e         ctrl;

  assign ctrl       = uop_ctrl_e'(bus.i_uop_ctrl);
  assign addr_inc   = addr_q + ADDR_W'(1);
  assign fetch_fire = bus.i_rdy && (ctrl == UOP_FETCH);
  assign nmi_edge   = nmi_prev_q && !bus.i_nmi_n;

  // Next-address, IR and entry-kind selection; everything holds while stalled.
  always_comb begin
    addr_d   = addr_q;
    ir_d     = ir_q;
    kind_d   = kind_q;
    take_nmi = 1'b0;
    if (bus.i_rdy) begin
      case (ctrl)
        UOP_JUMP:   addr_d = bus.i_uop_target;
        UOP_BRANCH: addr_d = bus.i_cond ? bus.i_uop_target : addr_inc;
        UOP_HOLD:   addr_d = bus.i_cond ? addr_inc : addr_q;
        UOP_FETCH: begin
          // Only the registered pending bit is seen here, so an NMI edge
          // arriving in this very cycle waits for the following FETCH.
          if (nmi_pending_q) begin
            addr_d   = ADDR_NMI;
            ir_d     = '0;
            kind_d   = KIND_NMI;
            take_nmi = 1'b1;
          end else if (!bus.i_irq_n && !bus.i_iflag) begin
            addr_d = ADDR_IRQ;
            ir_d   = '0;
            kind_d = KIND_IRQ;
          end else begin
            addr_d = bus.i_uop_entry;
            ir_d   = bus.i_opcode;
            kind_d = KIND_NONE;
          end
        end
        default:    addr_d = addr_inc;  // NEXT and unused codes 101-111
      endcase
    end
  end

  // A fresh edge wins over the clear, so an edge in the entry cycle is kept.
  always_comb begin
    nmi_pending_d = nmi_edge || (nmi_pending_q && !take_nmi);
  end

  // Sequencer state; NMI detector keeps running while i_rdy is low.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      addr_q        <= ADDR_RESET;
      ir_q          <= '0;
      kind_q        <= KIND_RESET;
      nmi_prev_q    <= 1'b1;
      nmi_pending_q <= 1'b0;
    end else begin
      addr_q        <= addr_d;
      ir_q          <= ir_d;
      kind_q        <= kind_d;
      nmi_prev_q    <= bus.i_nmi_n;
      nmi_pending_q <= nmi_pending_d;
    end
  end

  assign bus.o_uop_addr = addr_q;
  assign bus.o_ir       = ir_q;
  assign bus.o_int_kind = kind_q;
  assign bus.o_sync     = (ctrl == UOP_FETCH);

`ifdef CPU_6502_UOP_INSTR_CNT_EN
  logic [CNT_W-1:0] instr_cnt_q;

  // Counts every taken FETCH, interrupt entries included; wraps naturally.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      instr_cnt_q <= '0;
    end else if (fetch_fire) begin
      instr_cnt_q <= instr_cnt_q + CNT_W'(1);
    end
  end

  assign o_instr_cnt = instr_cnt_q;
`else
  logic unused_fetch_fire;
  assign unused_fetch_fire = fetch_fire;
`endif
endmodule
